// File: rtl/keccak_absorb_buffer.sv
// keccak_absorb_buffer: collects message words into rate-sized blocks for the
// Keccak permutation and applies SHA-3 / SHAKE multi-rate padding.
module keccak_absorb_buffer #(
    parameter int DW   = 64,
    parameter int RMAX = 168
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                cmode,
    input  logic [DW-1:0]             dt_i,
    input  logic                      valid,
    input  logic                      last,
    input  logic [$clog2(DW/8+1)-1:0] nbytes,
    output logic                      in_ready,
    output logic [8*RMAX-1:0]         dt_o,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic                      first,
    output logic                      last_blk
);
    localparam int NB = DW / 8;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_HOLD = 2'd1,
        S_PADQ = 2'd2
    } state_t;

    function automatic logic [7:0] rate_of(input logic [2:0] m);
        case (m)
            3'd0:    rate_of = 8'd144;
            3'd1:    rate_of = 8'd136;
            3'd2:    rate_of = 8'd104;
            3'd3:    rate_of = 8'd72;
            3'd4:    rate_of = 8'd168;
            3'd5:    rate_of = 8'd136;
            default: rate_of = 8'd136;
        endcase
    endfunction

    function automatic logic is_shake(input logic [2:0] m);
        is_shake = (m == 3'd4) || (m == 3'd5);
    endfunction

    function automatic logic [7:0] domain_of(input logic shake);
        if (shake) begin
            domain_of = 8'h1F;
        end else begin
            domain_of = 8'h06;
        end
    endfunction

    state_t              state_q, state_d;
    logic [8*RMAX-1:0]   mem_q, mem_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          rate_q, rate_d;
    logic                shake_q, shake_d;
    logic                pad_pend_q, pad_pend_d;
    logic                in_msg_q, in_msg_d;
    logic                seen_blk_q, seen_blk_d;
    logic                first_q, first_d;
    logic                last_blk_q, last_blk_d;
    logic                blk_valid_q, blk_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [7:0]          cur_rate_s;
    logic                cur_shake_s;
    int                  pos_s;
    int                  sum_s;

    // Next-state, byte-memory update and padding insertion.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        cnt_d       = cnt_q;
        rate_d      = rate_q;
        shake_d     = shake_q;
        pad_pend_d  = pad_pend_q;
        in_msg_d    = in_msg_q;
        seen_blk_d  = seen_blk_q;
        first_d     = first_q;
        last_blk_d  = last_blk_q;
        pos_s       = 0;
        sum_s       = 0;
        // Mode is frozen once the first word of a message has been taken.
        cur_rate_s  = in_msg_q ? rate_q  : rate_of(cmode);
        cur_shake_s = in_msg_q ? shake_q : is_shake(cmode);

        case (state_q)
            S_FILL: begin
                if (valid) begin
                    rate_d   = cur_rate_s;
                    shake_d  = cur_shake_s;
                    in_msg_d = !last;
                    for (int j = 0; j < NB; j++) begin
                        pos_s = int'(cnt_q) + j;
                        if ((!last || (j < int'(nbytes))) && (pos_s < RMAX)) begin
                            mem_d[pos_s*8 +: 8] = dt_i[DW-1-8*j -: 8];
                        end else begin
                            mem_d[pos_s*8 +: 8] = mem_d[pos_s*8 +: 8];
                        end
                    end
                    if (!last) begin
                        sum_s = int'(cnt_q) + NB;
                        cnt_d = 8'(sum_s);
                        if (sum_s >= int'(cur_rate_s)) begin
                            state_d    = S_HOLD;
                            last_blk_d = 1'b0;
                            first_d    = !seen_blk_q;
                        end else begin
                            state_d    = S_FILL;
                        end
                    end else begin
                        sum_s = int'(cnt_q) + int'(nbytes);
                        cnt_d = 8'(sum_s);
                        if (sum_s < int'(cur_rate_s)) begin
                            mem_d[sum_s*8 +: 8] = domain_of(cur_shake_s);
                            pos_s = int'(cur_rate_s) - 1;
                            mem_d[pos_s*8 +: 8] = mem_d[pos_s*8 +: 8] | 8'h80;
                            last_blk_d = 1'b1;
                        end else begin
                            // Block is exactly full: padding goes in an extra block.
                            pad_pend_d = 1'b1;
                            last_blk_d = 1'b0;
                        end
                        state_d = S_HOLD;
                        first_d = !seen_blk_q;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_HOLD: begin
                if (blk_ready) begin
                    mem_d      = '0;
                    cnt_d      = 8'd0;
                    first_d    = 1'b0;
                    seen_blk_d = !last_blk_q;
                    if (pad_pend_q) begin
                        mem_d[7:0] = domain_of(shake_q);
                        pos_s = int'(rate_q) - 1;
                        mem_d[pos_s*8 +: 8] = 8'h80;
                        pad_pend_d = 1'b0;
                        last_blk_d = 1'b1;
                        state_d    = S_PADQ;
                    end else begin
                        last_blk_d = 1'b0;
                        state_d    = S_FILL;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_PADQ: begin
                if (blk_ready) begin
                    mem_d      = '0;
                    cnt_d      = 8'd0;
                    first_d    = 1'b0;
                    last_blk_d = 1'b0;
                    seen_blk_d = 1'b0;
                    state_d    = S_FILL;
                end else begin
                    state_d = S_PADQ;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        blk_valid_d = (state_d != S_FILL);
        in_ready_d  = (state_d == S_FILL);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            mem_q       <= '0;
            cnt_q       <= 8'd0;
            rate_q      <= 8'd0;
            shake_q     <= 1'b0;
            pad_pend_q  <= 1'b0;
            in_msg_q    <= 1'b0;
            seen_blk_q  <= 1'b0;
            first_q     <= 1'b0;
            last_blk_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            cnt_q       <= cnt_d;
            rate_q      <= rate_d;
            shake_q     <= shake_d;
            pad_pend_q  <= pad_pend_d;
            in_msg_q    <= in_msg_d;
            seen_blk_q  <= seen_blk_d;
            first_q     <= first_d;
            last_blk_q  <= last_blk_d;
            blk_valid_q <= blk_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign dt_o      = mem_q;
    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign first     = first_q;
    assign last_blk  = last_blk_q;

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Directed self-checking bench for keccak_absorb_buffer (64-bit and 32-bit word instances).
module tb_keccak_absorb_buffer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]    cmode64, cmode32;
    logic [63:0]   dt64;
    logic [31:0]   dt32;
    logic          v64, v32, l64, l32;
    logic [3:0]    nb64;
    logic [2:0]    nb32;
    logic          ir64, ir32, bv64, bv32, br64, br32, f64, f32, lb64, lb32;
    logic [1343:0] dto64, dto32;

    int total = 0;
    int bad   = 0;

    keccak_absorb_buffer #(.DW(64), .RMAX(168)) u64 (
        .clk(clk), .rst_n(rst_n), .cmode(cmode64), .dt_i(dt64), .valid(v64),
        .last(l64), .nbytes(nb64), .in_ready(ir64), .dt_o(dto64),
        .blk_valid(bv64), .blk_ready(br64), .first(f64), .last_blk(lb64)
    );

    keccak_absorb_buffer #(.DW(32), .RMAX(168)) u32 (
        .clk(clk), .rst_n(rst_n), .cmode(cmode32), .dt_i(dt32), .valid(v32),
        .last(l32), .nbytes(nb32), .in_ready(ir32), .dt_o(dto32),
        .blk_valid(bv32), .blk_ready(br32), .first(f32), .last_blk(lb32)
    );

    task automatic push64(input logic [63:0] w, input logic l, input logic [3:0] nb);
        int budget;
        budget = 0;
        dt64 = w; l64 = l; nb64 = nb; v64 = 1'b1;
        while (!ir64 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!ir64) begin
            total++; bad++;
            $display("FAIL push64_timeout: in_ready got %0b want 1", ir64);
        end else begin
            @(posedge clk); #1;
        end
        v64 = 1'b0; l64 = 1'b0; nb64 = 4'd0;
    endtask

    task automatic push32(input logic [31:0] w, input logic l, input logic [2:0] nb);
        int budget;
        budget = 0;
        dt32 = w; l32 = l; nb32 = nb; v32 = 1'b1;
        while (!ir32 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!ir32) begin
            total++; bad++;
            $display("FAIL push32_timeout: in_ready got %0b want 1", ir32);
        end else begin
            @(posedge clk); #1;
        end
        v32 = 1'b0; l32 = 1'b0; nb32 = 3'd0;
    endtask

    task automatic consume64();
        br64 = 1'b1;
        @(posedge clk); #1;
        br64 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (ir64 !== 1'b1) begin bad++; $display("FAIL rst_in_ready64: got %0b want 1", ir64); end
        total++; if (bv64 !== 1'b0) begin bad++; $display("FAIL rst_blk_valid64: got %0b want 0", bv64); end
        total++; if (dto64 !== '0) begin bad++; $display("FAIL rst_dt_o64: got %h want 0", dto64); end
        total++; if ({f64, lb64} !== 2'b00) begin bad++; $display("FAIL rst_first_last64: got %b want 00", {f64, lb64}); end
        total++; if ({ir32, bv32, f32, lb32} !== 4'b1000) begin bad++; $display("FAIL rst_flags32: got %b want 1000", {ir32, bv32, f32, lb32}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty_msg();
        logic [1343:0] exp;
        exp = '0;
        exp[7:0]       = 8'h06;
        exp[1087:1080] = 8'h80;
        cmode64 = 3'd1;
        push64(64'h0, 1'b1, 4'd0);
        total++; if (bv64 !== 1'b1) begin bad++; $display("FAIL empty_blk_valid: got %0b want 1", bv64); end
        total++; if (ir64 !== 1'b0) begin bad++; $display("FAIL empty_in_ready: got %0b want 0", ir64); end
        total++; if ({f64, lb64} !== 2'b11) begin bad++; $display("FAIL empty_first_last: got %b want 11", {f64, lb64}); end
        total++; if (dto64 !== exp) begin bad++; $display("FAIL empty_block: got %h want %h", dto64, exp); end
        consume64();
        total++; if ({ir64, bv64} !== 2'b10) begin bad++; $display("FAIL empty_after_hs: got %b want 10", {ir64, bv64}); end
        total++; if (dto64 !== '0) begin bad++; $display("FAIL empty_cleared: got %h want 0", dto64); end
    endtask

    task automatic test_full_then_pad_block();
        logic [1343:0] exp;
        exp = '0;
        for (int w = 0; w < 17; w++) exp[64*w +: 64] = 64'h7766554433221100;
        cmode64 = 3'd1;
        for (int w = 0; w < 16; w++) push64(64'h0011223344556677, 1'b0, 4'd0);
        push64(64'h0011223344556677, 1'b1, 4'd8);
        total++; if ({bv64, f64, lb64} !== 3'b110) begin bad++; $display("FAIL full_b1_flags: got %b want 110", {bv64, f64, lb64}); end
        total++; if (dto64 !== exp) begin bad++; $display("FAIL full_b1_data: got %h want %h", dto64, exp); end
        consume64();
        exp = '0;
        exp[7:0]       = 8'h06;
        exp[1087:1080] = 8'h80;
        total++; if ({bv64, f64, lb64, ir64} !== 4'b1010) begin bad++; $display("FAIL full_b2_flags: got %b want 1010", {bv64, f64, lb64, ir64}); end
        total++; if (dto64 !== exp) begin bad++; $display("FAIL full_b2_data: got %h want %h", dto64, exp); end
        consume64();
        total++; if ({ir64, bv64} !== 2'b10) begin bad++; $display("FAIL full_after_b2: got %b want 10", {ir64, bv64}); end
    endtask

    task automatic test_shake_merged_pad();
        logic [1343:0] exp;
        exp = '0;
        for (int w = 0; w < 20; w++) exp[64*w +: 64] = 64'hA7A6A5A4A3A2A1A0;
        exp[1335:1280] = 56'hA6A5A4A3A2A1A0;
        exp[1343:1336] = 8'h9F;
        cmode64 = 3'd4;
        for (int w = 0; w < 20; w++) push64(64'hA0A1A2A3A4A5A6A7, 1'b0, 4'd0);
        total++; if (bv64 !== 1'b0) begin bad++; $display("FAIL shake_early_valid: got %0b want 0", bv64); end
        push64(64'hA0A1A2A3A4A5A6A7, 1'b1, 4'd7);
        total++; if ({bv64, f64, lb64} !== 3'b111) begin bad++; $display("FAIL shake_flags: got %b want 111", {bv64, f64, lb64}); end
        total++; if (dto64 !== exp) begin bad++; $display("FAIL shake_data: got %h want %h", dto64, exp); end
        consume64();
        total++; if ({ir64, bv64} !== 2'b10) begin bad++; $display("FAIL shake_after_hs: got %b want 10", {ir64, bv64}); end
    endtask

    task automatic test_dw32_sha512();
        logic [1343:0] exp;
        exp = '0;
        for (int w = 0; w < 16; w++) exp[32*w +: 32] = 32'h04030201;
        exp[519:512] = 8'h01;
        exp[527:520] = 8'h02;
        exp[535:528] = 8'h06;
        exp[575:568] = 8'h80;
        cmode32 = 3'd3;
        for (int w = 0; w < 16; w++) push32(32'h01020304, 1'b0, 3'd0);
        push32(32'h01020304, 1'b1, 3'd2);
        total++; if ({bv32, f32, lb32} !== 3'b111) begin bad++; $display("FAIL dw32_flags: got %b want 111", {bv32, f32, lb32}); end
        total++; if (dto32 !== exp) begin bad++; $display("FAIL dw32_data: got %h want %h", dto32, exp); end
        br32 = 1'b1;
        @(posedge clk); #1;
        br32 = 1'b0;
        total++; if ({ir32, bv32} !== 2'b10) begin bad++; $display("FAIL dw32_after_hs: got %b want 10", {ir32, bv32}); end
    endtask

    task automatic test_backpressure();
        logic [1343:0] exp;
        exp = '0;
        for (int w = 0; w < 17; w++) exp[64*w +: 64] = 64'h0807060504030201;
        cmode64 = 3'd1;
        for (int w = 0; w < 17; w++) push64(64'h0102030405060708, 1'b0, 4'd0);
        dt64 = 64'hAB00000000000000; l64 = 1'b1; nb64 = 4'd1; v64 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if ({bv64, ir64, f64, lb64} !== 4'b1010) begin bad++; $display("FAIL bp_flags cyc%0d: got %b want 1010", c, {bv64, ir64, f64, lb64}); end
            total++; if (dto64 !== exp) begin bad++; $display("FAIL bp_data cyc%0d: got %h want %h", c, dto64, exp); end
        end
        consume64();
        total++; if ({ir64, bv64} !== 2'b10) begin bad++; $display("FAIL bp_after_hs: got %b want 10", {ir64, bv64}); end
        @(posedge clk); #1;
        v64 = 1'b0; l64 = 1'b0; nb64 = 4'd0;
        exp = '0;
        exp[7:0]       = 8'hAB;
        exp[15:8]      = 8'h06;
        exp[1087:1080] = 8'h80;
        total++; if ({bv64, f64, lb64} !== 3'b101) begin bad++; $display("FAIL bp_held_flags: got %b want 101", {bv64, f64, lb64}); end
        total++; if (dto64 !== exp) begin bad++; $display("FAIL bp_held_data: got %h want %h", dto64, exp); end
        consume64();
    endtask

    task automatic test_mode_latch_reset();
        logic [1343:0] exp;
        exp = '0;
        for (int w = 0; w < 17; w++) exp[64*w +: 64] = 64'h5555555555555555;
        cmode64 = 3'd1;
        push64(64'h5555555555555555, 1'b0, 4'd0);
        cmode64 = 3'd3;
        for (int w = 0; w < 8; w++) push64(64'h5555555555555555, 1'b0, 4'd0);
        total++; if ({bv64, ir64} !== 2'b01) begin bad++; $display("FAIL latch_no_block_at72: got %b want 01", {bv64, ir64}); end
        for (int w = 0; w < 8; w++) push64(64'h5555555555555555, 1'b0, 4'd0);
        total++; if ({bv64, f64, lb64} !== 3'b110) begin bad++; $display("FAIL latch_block_at136: got %b want 110", {bv64, f64, lb64}); end
        total++; if (dto64 !== exp) begin bad++; $display("FAIL latch_data: got %h want %h", dto64, exp); end
        consume64();
        push64(64'hDEADBEEFDEADBEEF, 1'b0, 4'd0);
        push64(64'hDEADBEEFDEADBEEF, 1'b0, 4'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (dto64 !== '0) begin bad++; $display("FAIL midrst_dt_o: got %h want 0", dto64); end
        total++; if ({ir64, bv64, f64, lb64} !== 4'b1000) begin bad++; $display("FAIL midrst_flags: got %b want 1000", {ir64, bv64, f64, lb64}); end
        exp = '0;
        exp[7:0]     = 8'h06;
        exp[575:568] = 8'h80;
        push64(64'h0, 1'b1, 4'd0);
        total++; if ({bv64, f64, lb64} !== 3'b111) begin bad++; $display("FAIL postrst_flags: got %b want 111", {bv64, f64, lb64}); end
        total++; if (dto64 !== exp) begin bad++; $display("FAIL postrst_data: got %h want %h", dto64, exp); end
        consume64();
    endtask

    initial begin
        rst_n = 1'b0;
        cmode64 = 3'd1; cmode32 = 3'd1;
        dt64 = '0; dt32 = '0;
        v64 = 1'b0; v32 = 1'b0; l64 = 1'b0; l32 = 1'b0;
        nb64 = 4'd0; nb32 = 3'd0;
        br64 = 1'b0; br32 = 1'b0;
        #2;
        test_reset();
        test_empty_msg();
        test_full_then_pad_block();
        test_shake_merged_pad();
        test_dw32_sha512();
        test_backpressure();
        test_mode_latch_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_buffer.md
# keccak_absorb_buffer

Parametrised input buffer for the Keccak core, the next generation of the block input buffer. It accepts message words of configurable width under a valid/ready handshake, supports a partial final word, and applies SHA-3/SHAKE multi-rate padding. When padding does not fit in the current block, it generates an extra padding-only block. Sits between the host/bus interface and the Keccak permutation datapath; presents one rate-sized block at a time under a second valid/ready handshake.

## Interface
- DW, 64, input word width in bits; legal values 32 or 64 (all rates are multiples of 8 bytes)
- RMAX, 168, maximum rate in bytes; output width is 8*RMAX bits
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmode  in  3  mode: 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256
- dt_i  in  DW  message word; first byte in dt_i[DW-1:DW-8]
- valid  in  1  dt_i valid
- last  in  1  dt_i is the final word of the message
- nbytes  in  $clog2(DW/8+1)  valid bytes in dt_i when last=1 (0..DW/8); ignored when last=0 (full word)
- in_ready  out  1  buffer accepts a word this cycle
- dt_o  out  8*RMAX  block; byte k at dt_o[8k+7:8k]
- blk_valid  out  1  dt_o holds a complete block
- blk_ready  in  1  core consumes the block
- first  out  1  dt_o is the first block of a message (qualified by blk_valid)
- last_blk  out  1  dt_o is the final (padded) block of a message (qualified by blk_valid)

## Operation
- Rate in bytes R: 144, 136, 104, 72, 168, 136 for cmode 0..5; cmode 6/7 treated as 1.
- cmode is latched on the first accepted word of a message; changes mid-message are ignored.
- Byte memory mem[0..RMAX-1] plus byte counter cnt (8 bits); a word is accepted when valid && in_ready. Byte j of the word (dt_i[DW-1-8j -: 8]) is written to mem[cnt+j].
- States: FILL, HOLD, PADQ. in_ready = (state==FILL).
- FILL, accepted word, last=0: cnt += DW/8. If cnt reaches R, go to HOLD with last_blk=0.
- FILL, accepted word, last=1, n=nbytes: write n bytes. Let p = cnt+n.
  - If p<R: mem[p] = 0x06 (SHA3) or 0x1F (SHAKE), then mem[R-1] |= 0x80. When p==R-1, the byte is 0x86/0x9F. Go to HOLD with last_blk=1.
  - If p==R: go to HOLD with last_blk=0 and pad_pend=1.
- HOLD: blk_valid=1, and dt_o is held stable. On blk_ready, clear mem to zero and set cnt=0.
  - If pad_pend: load mem[0]=domain byte and mem[R-1]|=0x80, then go to PADQ.
  - Otherwise go to FILL.
- PADQ: behaves as HOLD with last_blk=1 and first=0. On blk_ready, clear and go to FILL.
- first=1 for the first block presented after the start of a message; 0 for all later blocks until a last_blk block is consumed.
- Bytes at index >= R are always 0.
- Reset clears mem, cnt, pad_pend, and latched mode, and enters FILL. Reset mid-message discards all data.

## Timing
- Reset values: in_ready=1, blk_valid=0, dt_o=0, first=0, last_blk=0.
- Word that completes a block accepted at cycle t: blk_valid=1 and in_ready=0 from t+1.
- Handshake at cycle t (blk_valid && blk_ready): at t+1, either in_ready=1 and blk_valid=0, or the PADQ block is presented (blk_valid=1). Minimum one-cycle bubble between blocks.
- blk_ready while blk_valid=0 is ignored. valid while in_ready=0 is not accepted; the source must hold the word.
- Throughput: R/(DW/8) accept cycles plus 1 handshake cycle per block with blk_ready tied high.

## Test plan
- DW=64, cmode=1, single word valid=1, last=1, nbytes=0 -> next cycle: blk_valid=1, first=1, last_blk=1, dt_o[7:0]=0x06, dt_o[1087:1080]=0x80, all other bytes 0.
- DW=64, cmode=1, 17 full words 0x0011223344556677, last on 17th with nbytes=8 -> block 1: first=1, last_blk=0, dt_o[7:0]=0x00, dt_o[63:56]=0x77. After consumption, block 2 at next cycle: first=0, last_blk=1, byte0=0x06, byte135=0x80.
- DW=64, cmode=4, 20 full words, 21st word last=1, nbytes=7 -> single block with byte167=0x9F, dt_o[1343:1336]=0x9F, last_blk=1.
- DW=32, cmode=3, 17 words, last word nbytes=2 (p=66) -> byte66=0x06, byte71=0x80, bytes 67..70 and 72..167 equal 0.
- Backpressure: hold blk_ready=0 for 5 cycles with valid=1 -> dt_o stable, in_ready=0, no word accepted. Then blk_ready=1 for one cycle -> in_ready=1 next cycle, and the held word is accepted into byte 0.
- Change cmode 1->3 after the first word of a message, and pulse rst_n=0 mid-block -> rate stays 136 for that message. After reset: cnt=0, dt_o=0, in_ready=1, blk_valid=0.
